// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a small byte FIFO.
// Sticky overflow flag, one-cycle framing error pulse, busy while a frame is in flight.
module uart_rx_fifo #(
   parameter int clk_freq   = 1000000,
   parameter int baud_rate  = 9600,
   parameter int fifo_depth = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       clear_err,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic [4:0] fifo_count,
   output logic       framing_error,
   output logic       overflow,
   output logic       busy
);

   localparam int P  = clk_freq / baud_rate;
   localparam int H  = P / 2;
   localparam int CW = $clog2(P + 1);
   localparam int AW = $clog2(fifo_depth);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic            rx_m, rx_s;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      idx, idx_n;
   logic [7:0]      shreg;
   logic            sample, push, ferr_n;

   logic [7:0]      mem [fifo_depth];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            full, pop, push_ok, ovf_evt;

   // two-flop synchronizer; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // receiver state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // next-state, counter/index updates and sample/push strobes
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sample  = 1'b0;
      push    = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            // no edge qualification: a low line is a start bit
            if (!rx_s) begin
               state_n = START;
               cnt_n   = CW'(H - 1);
            end
         end
         START: begin
            if (cnt != '0) cnt_n = cnt - 1'b1;
            else if (rx_s) state_n = IDLE;   // glitch shorter than half a bit
            else begin
               state_n = DATA;
               cnt_n   = CW'(P - 1);
               idx_n   = 3'd0;
            end
         end
         DATA: begin
            if (cnt != '0) cnt_n = cnt - 1'b1;
            else begin
               sample = 1'b1;
               cnt_n  = CW'(P - 1);
               if (idx == 3'd7) state_n = STOP;
               else             idx_n   = idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt != '0) cnt_n = cnt - 1'b1;
            else begin
               // back to IDLE mid stop bit so the next start edge is not missed
               state_n = IDLE;
               if (rx_s) push   = 1'b1;
               else      ferr_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // bit timing counter, bit index, shift register and error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         framing_error <= 1'b0;
      end else begin
         cnt           <= cnt_n;
         idx           <= idx_n;
         framing_error <= ferr_n;
         if (sample) shreg[idx] <= rx_s;
      end
   end

   assign busy       = (state != IDLE);
   assign data_valid = (fifo_count != 5'd0);
   assign full       = (fifo_count == 5'(fifo_depth));
   assign pop        = rd_en && data_valid;
   // when full, a simultaneous pop frees the slot the write lands in
   assign push_ok    = push && (!full || pop);
   assign ovf_evt    = push && full && !pop;
   assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;

   // FIFO storage (contents need no reset; count gates visibility)
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 5'd1;
            2'b01:   fifo_count <= fifo_count - 5'd1;
            default: fifo_count <= fifo_count;
         endcase
         // a new overflow wins over a coincident clear
         if (ovf_evt)        overflow <= 1'b1;
         else if (clear_err) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at default parameters.
module tb_uart_rx_fifo;

   localparam int P     = 104;   // 1000000 / 9600
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset, rx, rd_en, clear_err;
   logic [7:0] data_out;
   logic       data_valid, framing_error, overflow, busy;
   logic [4:0] fifo_count;

   int n_chk  = 0;
   int n_fail = 0;
   int fe_cnt = 0;
   int fe_run = 0;
   int fe_max = 0;
   int mcount = 0;
   logic [7:0] sb [$];

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         fe_exp;
      logic       push_exp;
   } vec_t;
   vec_t vecs [4];

   uart_rx_fifo dut (
      .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clear_err(clear_err),
      .data_out(data_out), .data_valid(data_valid), .fifo_count(fifo_count),
      .framing_error(framing_error), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   // count framing error pulses and their longest run
   always @(negedge clk) begin
      if (framing_error === 1'b1) begin
         fe_cnt++;
         fe_run++;
         if (fe_run > fe_max) fe_max = fe_run;
      end else fe_run = 0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // drive one frame; lat = cycles from start edge until data_valid first seen
   task automatic send_frame(input logic [7:0] d, input logic stop, output int lat);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      lat  = 0;
      for (int k = 0; k < 10 * P; k++) begin
         rx = bits[k / P];
         @(posedge clk);
         #1;
         if (lat == 0 && data_valid === 1'b1) lat = k + 1;
      end
      rx = 1'b1;
   endtask

   // model side of a received good frame
   task automatic expect_push(input logic [7:0] d);
      if (mcount < DEPTH) begin
         sb.push_back(d);
         mcount++;
      end
   endtask

   task automatic pop_chk(input string nm);
      logic [7:0] e;
      e = sb.pop_front();
      chk({nm, "_head"}, {24'd0, data_out}, {24'd0, e});
      rd_en = 1'b1;
      cycles(1);
      rd_en = 1'b0;
      mcount--;
      chk({nm, "_count"}, {27'd0, fifo_count}, mcount);
   endtask

   initial begin
      int lat, fe0;
      logic seen;
      reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clear_err = 1'b0;

      vecs[0] = '{d: 8'h55, stop: 1'b0, fe_exp: 1, push_exp: 1'b0};
      vecs[1] = '{d: 8'h3C, stop: 1'b1, fe_exp: 0, push_exp: 1'b1};
      vecs[2] = '{d: 8'h00, stop: 1'b1, fe_exp: 0, push_exp: 1'b1};
      vecs[3] = '{d: 8'h80, stop: 1'b1, fe_exp: 0, push_exp: 1'b1};

      cycles(3);
      chk("rst_valid", data_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_fe", framing_error, 0);
      reset = 1'b0;
      cycles(2 * P);

      // four back-to-back 0xFF frames fill the FIFO
      for (int i = 0; i < 4; i++) begin
         send_frame(8'hFF, 1'b1, lat);
         expect_push(8'hFF);
      end
      cycles(P);
      chk("fill_count", fifo_count, 4);
      chk("fill_ovf", overflow, 0);
      chk("fill_fe", fe_cnt, 0);

      // one more byte while full is dropped
      send_frame(8'h0E, 1'b1, lat);
      expect_push(8'h0E);
      cycles(P);
      chk("ovf_set", overflow, 1);
      chk("ovf_count", fifo_count, 4);
      for (int i = 0; i < 4; i++) pop_chk("drain");
      chk("ovf_sticky", overflow, 1);
      rd_en = 1'b1;              // pop while empty is ignored
      cycles(1);
      rd_en = 1'b0;
      chk("empty_pop", fifo_count, 0);
      clear_err = 1'b1;
      cycles(1);
      clear_err = 1'b0;
      chk("ovf_clr", overflow, 0);
      chk("drain_valid", data_valid, 0);

      // latency of a single byte into an empty FIFO
      send_frame(8'hA5, 1'b1, lat);
      expect_push(8'hA5);
      n_chk++;
      if (lat < 990 || lat > 992) begin
         n_fail++;
         $display("FAIL latency: got %0d expected 990..992", lat);
      end
      pop_chk("a5");
      chk("a5_valid", data_valid, 0);

      // table of frames including a bad stop bit
      foreach (vecs[i]) begin
         fe0 = fe_cnt;
         send_frame(vecs[i].d, vecs[i].stop, lat);
         if (vecs[i].push_exp) expect_push(vecs[i].d);
         cycles(2 * P);
         chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].fe_exp);
         chk($sformatf("vec%0d_count", i), fifo_count, mcount);
      end
      chk("fe_width", fe_max, 1);
      while (sb.size() > 0) pop_chk("vec_drain");

      // short glitch: busy pulses, nothing received
      fe0 = fe_cnt;
      seen = 1'b0;
      rx = 1'b0;
      for (int k = 0; k < 30; k++) begin
         cycles(1);
         if (busy === 1'b1) seen = 1'b1;
      end
      rx = 1'b1;
      for (int k = 0; k < 100; k++) begin
         cycles(1);
         if (busy === 1'b1) seen = 1'b1;
      end
      chk("glitch_busy_seen", seen, 1);
      chk("glitch_idle", busy, 0);
      chk("glitch_count", fifo_count, 0);
      chk("glitch_fe", fe_cnt - fe0, 0);

      // reset in the middle of data bit 4, with a byte already buffered
      send_frame(8'h11, 1'b1, lat);
      fe0 = fe_cnt;
      for (int k = 0; k < 5 * P + 50; k++) begin
         rx = (k < P) ? 1'b0 : 1'b1;
         cycles(1);
      end
      reset = 1'b1;
      cycles(3);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", data_valid, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_dout", data_out, 0);
      rx = 1'b1;
      reset = 1'b0;
      sb.delete();
      mcount = 0;
      cycles(6 * P);
      chk("post_rst_count", fifo_count, 0);
      chk("post_rst_fe", fe_cnt - fe0, 0);
      send_frame(8'h81, 1'b1, lat);
      expect_push(8'h81);
      cycles(P);
      chk("post_rst_valid", data_valid, 1);
      pop_chk("x81");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
